// File: rtl/fetch_sequencer_if.sv
// Fetch-sequencer handshake bundle: instruction-memory request/ready, decode ack/redirect/halt,
// datapath PC/IR strobes and PC mux select, plus status/debug outputs.
interface fetch_sequencer_if;
  logic        fetch_sequencer_mem_req_out;
  logic        fetch_sequencer_mem_ready_in;
  logic        fetch_sequencer_redirect_in;
  logic        fetch_sequencer_ir_ack_in;
  logic        fetch_sequencer_halt_in;
  logic        fetch_sequencer_pc_set_val_out;
  logic        fetch_sequencer_ir_set_val_out;
  logic [1:0]  fetch_sequencer_pc_mux_sel_out;
  logic        fetch_sequencer_ir_valid_out;
  logic        fetch_sequencer_timeout_out;
  logic [2:0]  fetch_sequencer_state_out;
  logic [31:0] fetch_sequencer_fetch_count_out;

  // master: the sequencer itself; slave: datapath, memory and decode around it
  modport master (
    output fetch_sequencer_mem_req_out,
    input  fetch_sequencer_mem_ready_in,
    input  fetch_sequencer_redirect_in,
    input  fetch_sequencer_ir_ack_in,
    input  fetch_sequencer_halt_in,
    output fetch_sequencer_pc_set_val_out,
    output fetch_sequencer_ir_set_val_out,
    output fetch_sequencer_pc_mux_sel_out,
    output fetch_sequencer_ir_valid_out,
    output fetch_sequencer_timeout_out,
    output fetch_sequencer_state_out,
    output fetch_sequencer_fetch_count_out
  );

  modport slave (
    input  fetch_sequencer_mem_req_out,
    output fetch_sequencer_mem_ready_in,
    output fetch_sequencer_redirect_in,
    output fetch_sequencer_ir_ack_in,
    output fetch_sequencer_halt_in,
    input  fetch_sequencer_pc_set_val_out,
    input  fetch_sequencer_ir_set_val_out,
    input  fetch_sequencer_pc_mux_sel_out,
    input  fetch_sequencer_ir_valid_out,
    input  fetch_sequencer_timeout_out,
    input  fetch_sequencer_state_out,
    input  fetch_sequencer_fetch_count_out
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: outputs decode state + inputs combinationally, zero-wait loop is 2 cycles/instr;
// halt freezes HOLD, memory stall counted to MEM_TIMEOUT then sticky ERR. FETCH_PERF_CNT_EN adds a fetch counter.
module fetch_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic              fetch_sequencer_clock_in,
  input  logic              fetch_sequencer_reset_in,
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_BOOT = 3'b001,
    S_REQ  = 3'b010,
    S_WAIT = 3'b011,
    S_HOLD = 3'b100,
    S_ERR  = 3'b101
  } state_e;

  localparam logic [1:0] SEL_RESET  = 2'b00;
  localparam logic [1:0] SEL_PC4    = 2'b01;
  localparam logic [1:0] SEL_TARGET = 2'b10;
  localparam logic [1:0] SEL_HOLD   = 2'b11;

  localparam bit             TO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  logic       mem_req;
  logic       pc_set_val;
  logic       ir_set_val;
  logic [1:0] pc_mux_sel;
  logic       ir_valid;

  always_ff @(posedge fetch_sequencer_clock_in or posedge fetch_sequencer_reset_in) begin
    if (fetch_sequencer_reset_in) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_req    = 1'b0;
    pc_set_val = 1'b0;
    ir_set_val = 1'b0;
    pc_mux_sel = SEL_HOLD;
    ir_valid   = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_BOOT;

      S_BOOT: begin
        pc_set_val = 1'b1;
        pc_mux_sel = SEL_RESET;
        state_d    = S_REQ;
      end

      S_REQ: begin
        mem_req = 1'b1;
        cnt_d   = '0;
        if (bus.fetch_sequencer_mem_ready_in) begin
          ir_set_val = 1'b1;
          state_d    = S_HOLD;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        mem_req = 1'b1;
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        // a late ready on the last allowed cycle still wins over the timeout
        if (bus.fetch_sequencer_mem_ready_in) begin
          ir_set_val = 1'b1;
          state_d    = S_HOLD;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          state_d = S_ERR;
        end
      end

      S_HOLD: begin
        ir_valid = 1'b1;
        if (bus.fetch_sequencer_redirect_in) begin
          pc_set_val = 1'b1;
          pc_mux_sel = SEL_TARGET;
          state_d    = S_REQ;
        end else if (bus.fetch_sequencer_halt_in) begin
          state_d = S_HOLD;
        end else if (bus.fetch_sequencer_ir_ack_in) begin
          pc_set_val = 1'b1;
          pc_mux_sel = SEL_PC4;
          state_d    = S_REQ;
        end
      end

      S_ERR: state_d = S_ERR;

      default: state_d = S_IDLE;
    endcase
  end

  assign timeout_d = timeout_q | (state_d == S_ERR);

  assign bus.fetch_sequencer_mem_req_out    = mem_req;
  assign bus.fetch_sequencer_pc_set_val_out = pc_set_val;
  assign bus.fetch_sequencer_ir_set_val_out = ir_set_val;
  assign bus.fetch_sequencer_pc_mux_sel_out = pc_mux_sel;
  assign bus.fetch_sequencer_ir_valid_out   = ir_valid;
  assign bus.fetch_sequencer_timeout_out    = timeout_q;
  assign bus.fetch_sequencer_state_out      = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;

  always_ff @(posedge fetch_sequencer_clock_in or posedge fetch_sequencer_reset_in) begin
    if (fetch_sequencer_reset_in) begin
      fetch_cnt_q <= '0;
    end else if (ir_set_val) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign bus.fetch_sequencer_fetch_count_out = fetch_cnt_q;
`else
  assign bus.fetch_sequencer_fetch_count_out = 32'h0;
`endif

endmodule
